// File: rtl/triangle_vertex_ctrl.sv
// Vertex editor for the VGA triangle renderer.
// Four active-low board keys are synchronised, debounced and edge-detected.
// KEY[0]/KEY[1] step the selected coordinate up/down, with auto-repeat while held.
// KEY[2] toggles the edited axis, and KEY[3] cycles through the three vertices.
// Edits land in shadow registers and are copied to the ponto outputs only on frame_start.
// Ports:
//   CLOCK_50, reset        clock and synchronous active-high reset
//   KEY[3:0]               raw push buttons (0 = pressed)
//   frame_start            one-cycle commit strobe from the renderer
//   ponto{1,2,3}_{x,y}     committed vertex coordinates
//   sel_vertex, sel_axis   current edit selection
//   pending                shadow holds uncommitted changes
module triangle_vertex_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned STEP_X          = 4,
  parameter int unsigned STEP_Y          = 2,
  parameter int unsigned X_MIN           = 285,
  parameter int unsigned X_MAX           = 1554,
  parameter int unsigned Y_MIN           = 35,
  parameter int unsigned Y_MAX           = 514,
  parameter int unsigned P1_X            = 400,
  parameter int unsigned P1_Y            = 80,
  parameter int unsigned P2_X            = 700,
  parameter int unsigned P2_Y            = 500,
  parameter int unsigned P3_X            = 1200,
  parameter int unsigned P3_Y            = 450
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic        frame_start,
  output logic [10:0] ponto1_x,
  output logic [9:0]  ponto1_y,
  output logic [10:0] ponto2_x,
  output logic [9:0]  ponto2_y,
  output logic [10:0] ponto3_x,
  output logic [9:0]  ponto3_y,
  output logic [1:0]  sel_vertex,
  output logic        sel_axis,
  output logic        pending
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
  localparam int unsigned CW     = 12;

  typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_e;

  // Two-flop synchroniser; flops reset to the released level (KEY high)
  logic [3:0] sync1, sync2, sample, db_state, db_prev, press;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1   <= 4'hF;
      sync2   <= 4'hF;
      db_prev <= 4'h0;
    end else begin
      sync1   <= KEY;
      sync2   <= sync1;
      db_prev <= db_state;
    end
  end

  assign sample = ~sync2;
  assign press  = db_state & ~db_prev;

  // Per-key debounce: count consecutive samples that disagree with the accepted state
  for (genvar k = 0; k < 4; k++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            state;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        cnt   <= '0;
        state <= 1'b0;
      end else if (sample[k] == state) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db_state[k] = state;
  end

  // Auto-repeat for inc (0) and dec (1); the press itself is the first move
  logic [1:0] move;

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    rpt_state_e      state, state_next;
    logic [RC_W-1:0] cnt, cnt_next;
    logic            mv;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state <= RPT_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mv         = 1'b0;
      unique case (state)
        RPT_IDLE: begin
          if (press[k]) begin
            state_next = RPT_HOLD;
            cnt_next   = '0;
            mv         = 1'b1;
          end
        end
        RPT_HOLD: begin
          if (!db_state[k]) begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
          end else if (cnt == RC_W'(REPEAT_DELAY - 1)) begin
            state_next = RPT_REPEAT;
            cnt_next   = '0;
            mv         = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!db_state[k]) begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
          end else if (cnt == RC_W'(REPEAT_PERIOD - 1)) begin
            cnt_next = '0;
            mv       = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign move[k] = mv;
  end

  // Shadow coordinates being edited
  logic [10:0] sx [3];
  logic [9:0]  sy [3];

  // Saturating step on the currently selected coordinate
  logic          inc_ev, dec_ev, changed;
  logic [CW-1:0] cur_val, step, lim_min, lim_max, new_val;

  assign inc_ev = move[0] & ~move[1];
  assign dec_ev = move[1] & ~move[0];

  always_comb begin
    cur_val = sel_axis ? CW'(sy[0]) : CW'(sx[0]);
    case (sel_vertex)
      2'd1:    cur_val = sel_axis ? CW'(sy[1]) : CW'(sx[1]);
      2'd2:    cur_val = sel_axis ? CW'(sy[2]) : CW'(sx[2]);
      default: ;
    endcase
    step    = sel_axis ? CW'(STEP_Y) : CW'(STEP_X);
    lim_min = sel_axis ? CW'(Y_MIN)  : CW'(X_MIN);
    lim_max = sel_axis ? CW'(Y_MAX)  : CW'(X_MAX);
    new_val = cur_val;
    if (inc_ev) begin
      new_val = (cur_val + step > lim_max) ? lim_max : cur_val + step;
    end else if (dec_ev) begin
      new_val = (cur_val < lim_min + step) ? lim_min : cur_val - step;
    end
  end

  assign changed = (new_val != cur_val);

  // Shadow, selection, commit and pending state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sx[0] <= 11'(P1_X);  sy[0] <= 10'(P1_Y);
      sx[1] <= 11'(P2_X);  sy[1] <= 10'(P2_Y);
      sx[2] <= 11'(P3_X);  sy[2] <= 10'(P3_Y);
      ponto1_x <= 11'(P1_X);  ponto1_y <= 10'(P1_Y);
      ponto2_x <= 11'(P2_X);  ponto2_y <= 10'(P2_Y);
      ponto3_x <= 11'(P3_X);  ponto3_y <= 10'(P3_Y);
      sel_vertex <= 2'd0;
      sel_axis   <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (changed) begin
        if (sel_axis) begin
          case (sel_vertex)
            2'd1:    sy[1] <= new_val[9:0];
            2'd2:    sy[2] <= new_val[9:0];
            default: sy[0] <= new_val[9:0];
          endcase
        end else begin
          case (sel_vertex)
            2'd1:    sx[1] <= new_val[10:0];
            2'd2:    sx[2] <= new_val[10:0];
            default: sx[0] <= new_val[10:0];
          endcase
        end
      end
      // Commit copies the pre-move shadow; a coincident change keeps pending set
      if (frame_start) begin
        ponto1_x <= sx[0];  ponto1_y <= sy[0];
        ponto2_x <= sx[1];  ponto2_y <= sy[1];
        ponto3_x <= sx[2];  ponto3_y <= sy[2];
      end
      if (changed)          pending <= 1'b1;
      else if (frame_start) pending <= 1'b0;
      if (press[2]) sel_axis <= ~sel_axis;
      if (press[3]) sel_vertex <= (sel_vertex == 2'd2) ? 2'd0 : sel_vertex + 2'd1;
    end
  end

endmodule

// File: tb/tb_triangle_vertex_ctrl.sv
// Directed bench for triangle_vertex_ctrl with short debounce/repeat timing.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_triangle_vertex_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key;
  logic        frame_start;
  logic [10:0] p1x, p2x, p3x;
  logic [9:0]  p1y, p2y, p3y;
  logic [1:0]  sel_vertex;
  logic        sel_axis;
  logic        pending;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  triangle_vertex_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .KEY        (key),
    .frame_start(frame_start),
    .ponto1_x   (p1x),
    .ponto1_y   (p1y),
    .ponto2_x   (p2x),
    .ponto2_y   (p2y),
    .ponto3_x   (p3x),
    .ponto3_y   (p3y),
    .sel_vertex (sel_vertex),
    .sel_axis   (sel_axis),
    .pending    (pending)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold one key low for n rising edges, then release it
  task automatic hold_key(input int idx, input int n);
    @(negedge clk);
    key[idx] = 1'b0;
    repeat (n) @(negedge clk);
    key[idx] = 1'b1;
  endtask

  task automatic tap_key(input int idx);
    hold_key(idx, 10);
    idle(20);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    key         = 4'hF;
    frame_start = 1'b0;
    idle(5);
    reset = 1'b0;

    // Reset state survives an idle frame
    idle(50);
    pulse_frame();
    idle(50);
    check_val("rst_p1x", 32'(p1x), 400);
    check_val("rst_p1y", 32'(p1y), 80);
    check_val("rst_p2x", 32'(p2x), 700);
    check_val("rst_p2y", 32'(p2y), 500);
    check_val("rst_p3x", 32'(p3x), 1200);
    check_val("rst_p3y", 32'(p3y), 450);
    check_val("rst_selv", 32'(sel_vertex), 0);
    check_val("rst_sela", 32'(sel_axis), 0);
    check_val("rst_pend", 32'(pending), 0);

    // A 3-cycle glitch is filtered out
    hold_key(0, 3);
    idle(20);
    check_val("glitch_pend", 32'(pending), 0);

    // One inc press: visible only after the commit
    tap_key(0);
    check_val("inc_pend_pre", 32'(pending), 1);
    check_val("inc_p1x_pre", 32'(p1x), 400);
    pulse_frame();
    check_val("inc_p1x_post", 32'(p1x), 404);
    check_val("inc_pend_post", 32'(pending), 0);

    // Select vertex 3, y axis; hold dec 40 cycles -> press plus 4 repeats
    tap_key(3);
    tap_key(3);
    tap_key(2);
    check_val("sel_v2", 32'(sel_vertex), 2);
    check_val("sel_y", 32'(sel_axis), 1);
    hold_key(1, 40);
    idle(20);
    check_val("rpt_pend", 32'(pending), 1);
    pulse_frame();
    check_val("rpt_p3y", 32'(p3y), 440);
    check_val("rpt_p3x", 32'(p3x), 1200);

    // Back to x axis; long inc hold saturates at X_MAX
    tap_key(2);
    check_val("sel_x", 32'(sel_axis), 0);
    hold_key(0, 600);
    idle(20);
    check_val("sat_pend_pre", 32'(pending), 1);
    pulse_frame();
    check_val("sat_p3x", 32'(p3x), 1554);
    check_val("sat_pend_post", 32'(pending), 0);
    tap_key(0);
    check_val("sat_no_pend", 32'(pending), 0);
    pulse_frame();
    check_val("sat_p3x_hold", 32'(p3x), 1554);

    // Inc and dec together cancel
    @(negedge clk);
    key[1:0] = 2'b00;
    repeat (10) @(negedge clk);
    key[1:0] = 2'b11;
    idle(20);
    check_val("both_pend", 32'(pending), 0);
    pulse_frame();
    check_val("both_p3x", 32'(p3x), 1554);

    // Dec move lands on the same edge as frame_start
    @(negedge clk);
    key[1] = 1'b0;
    repeat (6) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_val("coin_p3x", 32'(p3x), 1554);
    check_val("coin_pend", 32'(pending), 1);
    repeat (3) @(negedge clk);
    key[1] = 1'b1;
    idle(20);
    check_val("coin_pend_hold", 32'(pending), 1);
    pulse_frame();
    check_val("coin_p3x_next", 32'(p3x), 1550);
    check_val("coin_pend_clr", 32'(pending), 0);

    // Reset in the middle of auto-repeat
    @(negedge clk);
    key[1] = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    key[1] = 1'b1;
    reset  = 1'b0;
    check_val("mid_rst_p3x", 32'(p3x), 1200);
    check_val("mid_rst_pend", 32'(pending), 0);
    check_val("mid_rst_selv", 32'(sel_vertex), 0);
    idle(50);
    check_val("mid_rst_quiet", 32'(pending), 0);
    pulse_frame();
    check_val("mid_rst_p3x_f", 32'(p3x), 1200);
    check_val("mid_rst_p3y_f", 32'(p3y), 450);
    check_val("mid_rst_p1x_f", 32'(p1x), 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
